// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse train generator: mode codes and FSM
// state encoding.
package pulse_gen_pkg;

   localparam logic [1:0] MODE_CONT    = 2'd0;
   localparam logic [1:0] MODE_ONESHOT = 2'd1;
   localparam logic [1:0] MODE_BURST   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN_HI = 2'd1,
      ST_RUN_LO = 2'd2
   } state_e;

endpackage

// File: rtl/pulse_cfg_latch.sv
// Captures the train configuration when a start is accepted and holds the
// derived effective period/width so the running train is immune to config
// changes.
// Ports:
//   clk, nrst           clock, async active-low reset
//   load                capture strobe (accepted start)
//   mode .. burst_len   raw configuration inputs
//   mode_q              latched mode (3 folded to ONESHOT)
//   per_q               effective period P, at least 2
//   wid_q               effective high width W, 1 .. P-1
//   blen_q              effective burst length, at least 1
module pulse_cfg_latch
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int BURST_W = 8,
   parameter int PW      = CNT_W + 4
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               load,
   input  logic [1:0]         mode,
   input  logic [1:0]         rate_sel,
   input  logic [CNT_W-1:0]   period,
   input  logic [CNT_W-1:0]   width,
   input  logic [BURST_W-1:0] burst_len,
   output logic [1:0]         mode_q,
   output logic [PW-1:0]      per_q,
   output logic [PW-1:0]      wid_q,
   output logic [BURST_W-1:0] blen_q
);

   logic [1:0]         mode_d;
   logic [PW-1:0]      per_d, wid_d, p_raw, p_eff, w_ext;
   logic [BURST_W-1:0] blen_d;

   // PW leaves one bit above CNT_W+3 so all-ones period at rate_sel=3 cannot wrap.
   always_comb begin
      p_raw  = (PW'(period) + PW'(1)) << rate_sel;
      p_eff  = (p_raw < PW'(2)) ? PW'(2) : p_raw;
      w_ext  = PW'(width);
      mode_d = mode_q;
      per_d  = per_q;
      wid_d  = wid_q;
      blen_d = blen_q;
      if (load) begin
         mode_d = (mode == 2'd3) ? MODE_ONESHOT : mode;
         per_d  = p_eff;
         if (width == '0)
            wid_d = PW'(1);
         else if (w_ext >= p_eff)
            wid_d = p_eff - PW'(1);   // keep at least one low cycle
         else
            wid_d = w_ext;
         blen_d = (burst_len == '0) ? BURST_W'(1) : burst_len;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mode_q <= MODE_CONT;
         per_q  <= '0;
         wid_q  <= '0;
         blen_q <= '0;
      end else begin
         mode_q <= mode_d;
         per_q  <= per_d;
         wid_q  <= wid_d;
         blen_q <= blen_d;
      end
   end

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator: continuous, one-shot or burst trains
// with period/width/prescale control, start/stop, busy/done status.
// Ports:
//   clk, nrst      clock, async active-low reset
//   start, stop    launch (IDLE only) / synchronous abort (stop wins)
//   mode           0 CONT, 1 ONESHOT, 2 BURST, 3 ONESHOT
//   rate_sel       prescale, P = (period+1) << rate_sel
//   period, width  base period minus one, high time
//   burst_len      pulses per burst (0 means 1)
//   out            registered pulse output
//   busy, done     train running / 1-cycle completion strobe
//   pulse_cnt      pulses emitted since last start
module pulse_train_gen
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               start,
   input  logic               stop,
   input  logic [1:0]         mode,
   input  logic [1:0]         rate_sel,
   input  logic [CNT_W-1:0]   period,
   input  logic [CNT_W-1:0]   width,
   input  logic [BURST_W-1:0] burst_len,
   output logic               out,
   output logic               busy,
   output logic               done,
   output logic [BURST_W-1:0] pulse_cnt
);

   localparam int PW = CNT_W + 4;

   state_e             state_q, state_d;
   logic [PW-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [BURST_W-1:0] pcnt_q, pcnt_d;
   logic               out_q, out_d, busy_q, busy_d, done_q, done_d;
   logic               load;
   logic [1:0]         mode_l;
   logic [PW-1:0]      per_l, wid_l;
   logic [BURST_W-1:0] blen_l;

   pulse_cfg_latch #(.CNT_W(CNT_W), .BURST_W(BURST_W), .PW(PW)) u_cfg (
      .clk       (clk),
      .nrst      (nrst),
      .load      (load),
      .mode      (mode),
      .rate_sel  (rate_sel),
      .period    (period),
      .width     (width),
      .burst_len (burst_len),
      .mode_q    (mode_l),
      .per_q     (per_l),
      .wid_q     (wid_l),
      .blen_q    (blen_l)
   );

   // cnt_q is the cycle index inside the current period: 0..W-1 high, W..P-1 low.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      done_d  = 1'b0;
      load    = 1'b0;
      cnt_inc = cnt_q + PW'(1);
      unique case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_RUN_HI;
               cnt_d   = '0;
               pcnt_d  = BURST_W'(1);
               load    = 1'b1;
            end
         end
         ST_RUN_HI: begin
            cnt_d = cnt_inc;
            if (cnt_inc == wid_l) state_d = ST_RUN_LO;
         end
         ST_RUN_LO: begin
            if (cnt_inc == per_l) begin
               cnt_d = '0;
               if (mode_l == MODE_CONT ||
                   (mode_l == MODE_BURST && pcnt_q < blen_l)) begin
                  state_d = ST_RUN_HI;
                  pcnt_d  = pcnt_q + BURST_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort overrides everything: no done, pulse count frozen.
      if (stop && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         pcnt_d  = pcnt_q;
         done_d  = 1'b0;
      end
      out_d  = (state_d == ST_RUN_HI);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pcnt_q  <= pcnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out       = out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: stimulus pushes the expected
// post-edge output snapshot per cycle; a negedge monitor pops and compares.
module tb_pulse_train_gen;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [1:0]  rate_sel = 2'd0;
   logic [31:0] period = '0;
   logic [31:0] width = '0;
   logic [7:0]  burst_len = '0;
   logic        out, busy, done;
   logic [7:0]  pulse_cnt;

   pulse_train_gen #(.CNT_W(32), .BURST_W(8)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .rate_sel  (rate_sel),
      .period    (period),
      .width     (width),
      .burst_len (burst_len),
      .out       (out),
      .busy      (busy),
      .done      (done),
      .pulse_cnt (pulse_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       o;
      logic       b;
      logic       d;
      logic [7:0] pc;
      string      nm;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;

   always @(negedge clk) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         n_vec++;
         if ({out, busy, done, pulse_cnt} !== {mon_e.o, mon_e.b, mon_e.d, mon_e.pc}) begin
            n_err++;
            $display("FAIL %s @%0t: got out=%0b busy=%0b done=%0b pulse_cnt=%0d, want out=%0b busy=%0b done=%0b pulse_cnt=%0d",
                     mon_e.nm, $time, out, busy, done, pulse_cnt, mon_e.o, mon_e.b, mon_e.d, mon_e.pc);
         end
      end
   end

   task automatic push_exp(input logic o, input logic b, input logic d,
                           input logic [7:0] pc, input string nm);
      exp_t e;
      e.o = o; e.b = b; e.d = d; e.pc = pc; e.nm = nm;
      q.push_back(e);
   endtask

   // Apply start/stop for one edge; expectation is the state after that edge.
   task automatic cyc(input logic st, input logic sp, input logic o, input logic b,
                      input logic d, input logic [7:0] pc, input string nm);
      start = st;
      stop  = sp;
      #1;
      push_exp(o, b, d, pc, nm);
      @(negedge clk);
   endtask

   task automatic cfg(input logic [1:0] m, input logic [1:0] r, input logic [31:0] p,
                      input logic [31:0] w, input logic [7:0] bl);
      mode = m; rate_sel = r; period = p; width = w; burst_len = bl;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      cyc(0, 0, 0, 0, 0, 8'd0, "reset_state");
      nrst = 1'b1;

      // CONTINUOUS: P=(4+1)<<1=10, W=3; mid-run config change must be ignored
      cfg(2'd0, 2'd1, 32'd4, 32'd3, 8'd0);
      cyc(1, 0, 1, 1, 0, 8'd1, "cont_start");
      for (int k = 1; k < 30; k++) begin
         if (k == 5) cfg(2'd1, 2'd0, 32'd0, 32'd0, 8'd1);
         cyc(0, 0, (k % 10) < 3, 1, 0, 8'(k / 10 + 1), "cont_run");
      end
      cyc(0, 1, 0, 0, 0, 8'd3, "cont_stop");
      cyc(0, 0, 0, 0, 0, 8'd3, "cont_idle");

      // BURST: 3 pulses, P=6, W=2, done the cycle after the last low phase
      cfg(2'd2, 2'd0, 32'd5, 32'd2, 8'd3);
      cyc(1, 0, 1, 1, 0, 8'd1, "burst_start");
      for (int k = 1; k < 18; k++)
         cyc(0, 0, (k % 6) < 2, 1, 0, 8'(k / 6 + 1), "burst_run");
      cyc(0, 0, 0, 0, 1, 8'd3, "burst_done");
      cyc(0, 0, 0, 0, 0, 8'd3, "burst_after");

      // Clamp P=2, W=1: toggling output
      cfg(2'd0, 2'd0, 32'd0, 32'd0, 8'd0);
      cyc(1, 0, 1, 1, 0, 8'd1, "toggle_start");
      for (int k = 1; k < 6; k++)
         cyc(0, 0, (k % 2) == 0, 1, 0, 8'(k / 2 + 1), "toggle_run");
      cyc(0, 1, 0, 0, 0, 8'd3, "toggle_stop");

      // Width clamp: P=8, width=100 -> high 7, low 1 (ONESHOT)
      cfg(2'd1, 2'd0, 32'd7, 32'd100, 8'd0);
      cyc(1, 0, 1, 1, 0, 8'd1, "wclamp_start");
      for (int k = 1; k < 8; k++)
         cyc(0, 0, k < 7, 1, 0, 8'd1, "wclamp_run");
      cyc(0, 0, 0, 0, 1, 8'd1, "wclamp_done");

      // start and stop together: stop wins
      cyc(1, 1, 0, 0, 0, 8'd1, "start_stop_same");
      cyc(0, 0, 0, 0, 0, 8'd1, "start_stop_idle");

      // ONESHOT P=4 W=1; start while busy ignored; start during done accepted
      cfg(2'd1, 2'd0, 32'd3, 32'd1, 8'd0);
      cyc(1, 0, 1, 1, 0, 8'd1, "os_start");
      cyc(1, 0, 0, 1, 0, 8'd1, "start_busy_ignored");
      cyc(0, 0, 0, 1, 0, 8'd1, "os_low");
      cyc(0, 0, 0, 1, 0, 8'd1, "os_low");
      cyc(0, 0, 0, 0, 1, 8'd1, "os_done");
      mode = 2'd3;
      cyc(1, 0, 1, 1, 0, 8'd1, "start_during_done");
      for (int k = 1; k < 4; k++)
         cyc(0, 0, 0, 1, 0, 8'd1, "mode3_low");
      cyc(0, 0, 0, 0, 1, 8'd1, "mode3_done");
      cyc(0, 0, 0, 0, 0, 8'd1, "mode3_idle");

      // CONTINUOUS 300 pulses: pulse_cnt wraps to 44, never done
      cfg(2'd0, 2'd0, 32'd0, 32'd0, 8'd0);
      cyc(1, 0, 1, 1, 0, 8'd1, "wrap_start");
      for (int k = 1; k < 600; k++)
         cyc(0, 0, (k % 2) == 0, 1, 0, 8'((k / 2 + 1) % 256), "wrap_run");
      cyc(0, 1, 0, 0, 0, 8'd44, "wrap_stop");

      // Async reset mid-burst: immediate clear, no done afterwards
      cfg(2'd2, 2'd0, 32'd5, 32'd2, 8'd3);
      cyc(1, 0, 1, 1, 0, 8'd1, "rst_burst_start");
      for (int k = 1; k < 9; k++)
         cyc(0, 0, (k % 6) < 2, 1, 0, 8'(k / 6 + 1), "rst_burst_run");
      @(posedge clk);
      #2;
      nrst = 1'b0;
      push_exp(0, 0, 0, 8'd0, "async_reset");
      @(negedge clk);
      cyc(0, 0, 0, 0, 0, 8'd0, "reset_hold");
      nrst = 1'b1;
      for (int k = 0; k < 8; k++)
         cyc(0, 0, 0, 0, 0, 8'd0, "post_reset_no_done");

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
